// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_FULL = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// PC register: redirect load has priority over the +4 step.
module program_counter
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc,
  output logic [31:0] pc_inc
);

  // Plain 32-bit add, so the top word wraps to zero.
  assign pc_inc = pc + 32'd4;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     pc <= RESET_PC;
    else if (load)  pc <= word_align(load_addr);
    else if (inc)   pc <= pc_inc;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, IF/ID register and a one-word
// skid buffer for a response that lands while decode is stalled.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        if_valid
);

  if_state_e   state;
  ifid_t       ifid_q;
  logic [31:0] hold_q;
  logic [31:0] pc, pc_inc;
  logic        slot_free, pc_step;

  assign slot_free   = !if_valid || !stall;
  assign instruction = ifid_q.instr;
  assign pc_plus4    = ifid_q.pc_plus4;

  // PC advances only when a word actually enters the IF/ID register.
  always_comb begin
    pc_step = 1'b0;
    if (!pc_src) begin
      case (state)
        S_REQ:   pc_step = imem_ack && slot_free;
        S_FULL:  pc_step = !stall;
        default: pc_step = 1'b0;
      endcase
    end
  end

  program_counter #(.RESET_PC(RESET_PC)) u_pc (
    .clock     (clock),
    .reset     (reset),
    .load      (pc_src),
    .load_addr (pc_target),
    .inc       (pc_step),
    .pc        (pc),
    .pc_inc    (pc_inc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      ifid_q    <= '0;
      if_valid  <= 1'b0;
      hold_q    <= NOP_WORD;
    end else if (pc_src) begin
      // Flush beats stall and enable; an issued request must still complete.
      if_valid     <= 1'b0;
      ifid_q.instr <= NOP_WORD;
      hold_q       <= NOP_WORD;
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end else begin
            state    <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (!stall) if_valid <= 1'b0;
          if (enable && slot_free) begin
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            if (slot_free) begin
              ifid_q   <= '{instr: imem_rdata, pc_plus4: pc_inc};
              if_valid <= 1'b1;
              if (enable) begin
                imem_addr <= pc_inc;
              end else begin
                state    <= S_IDLE;
                imem_req <= 1'b0;
              end
            end else begin
              hold_q   <= imem_rdata;
              state    <= S_FULL;
              imem_req <= 1'b0;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        S_DROP: begin
          if (!stall) if_valid <= 1'b0;
          if (imem_ack) begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end
        end
        S_FULL: begin
          if (!stall) begin
            ifid_q   <= '{instr: hold_q, pc_plus4: pc_inc};
            if_valid <= 1'b1;
            if (enable) begin
              state     <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc_inc;
            end else begin
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table plus scoreboarded streams.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset, enable, stall, pc_src;
  logic [31:0] pc_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instruction, pc_plus4;
  logic        if_valid;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock(clock), .reset(reset), .enable(enable), .stall(stall),
    .pc_src(pc_src), .pc_target(pc_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_plus4(pc_plus4), .if_valid(if_valid)
  );

  // Memory returns the address as data.
  assign imem_rdata = imem_addr;

  int n_chk = 0, n_pass = 0;
  int ack_delay = 0, wait_cnt = 0;
  logic sb_on = 1'b0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  ifid_t sbq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory model and request-stability check, evaluated away from the active edge.
  always @(negedge clock) begin
    if (prev_req && !prev_ack && imem_req && reset)
      check("addr_stable", imem_addr, prev_addr);
    if (ack_delay == 0) imem_ack = 1'b1;
    else if (!imem_req || imem_ack) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      wait_cnt++;
      imem_ack = (wait_cnt >= ack_delay);
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
  end

  // Scoreboard: a word is consumed at the edge where if_valid=1, stall=0, no flush.
  always @(negedge clock) begin
    if (sb_on && reset && if_valid && !stall && !pc_src) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL sb_extra: got %0h/%0h expected no word", instruction, pc_plus4);
      end else begin
        ifid_t e;
        e = sbq.pop_front();
        check("sb_word", {instruction, pc_plus4}, e);
      end
    end
  end

  task automatic start(input logic en, input int dly);
    reset = 1'b0; enable = en; stall = 1'b0; pc_src = 1'b0; pc_target = '0;
    sb_on = 1'b0; sbq.delete(); ack_delay = dly;
    tick(); tick();
    check("rst_outs", {imem_req, imem_addr, if_valid, instruction, pc_plus4}, '0);
    check("rst_state", dut.state, S_IDLE);
    reset = 1'b1;
  endtask

  task automatic push(input logic [31:0] a);
    sbq.push_back('{instr: a, pc_plus4: a + 32'd4});
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    sb_on = 1'b0;
    enable = 1'b0;
    check(name, sbq.size(), 0);
  endtask

  typedef struct {
    logic en, st, src;
    logic [31:0] tgt;
    logic req;
    logic [31:0] addr;
    logic vld;
    logic [31:0] ins, p4;
  } vec_t;
  vec_t tbl[13];

  initial begin
    // inputs for edge k ; expected outputs after edge k (ack tied 1)
    tbl[0]  = '{1,0,0,32'h0,        1,32'h0,        0,32'h0,        32'h0};
    tbl[1]  = '{1,0,0,32'h0,        1,32'h4,        1,32'h0,        32'h4};
    tbl[2]  = '{1,0,0,32'h0,        1,32'h8,        1,32'h4,        32'h8};
    tbl[3]  = '{1,1,0,32'h0,        0,32'h8,        1,32'h4,        32'h8};
    tbl[4]  = '{1,1,0,32'h0,        0,32'h8,        1,32'h4,        32'h8};
    tbl[5]  = '{0,0,0,32'h0,        0,32'h8,        1,32'h8,        32'hC};
    tbl[6]  = '{0,0,0,32'h0,        0,32'h8,        0,32'h8,        32'hC};
    tbl[7]  = '{1,0,1,32'h42,       0,32'h8,        0,32'h0,        32'hC};
    tbl[8]  = '{1,0,0,32'h0,        1,32'h40,       0,32'h0,        32'hC};
    tbl[9]  = '{1,0,0,32'h0,        1,32'h44,       1,32'h40,       32'h44};
    tbl[10] = '{1,1,1,32'hFFFF_FFFC,0,32'h44,       0,32'h0,        32'h44};
    tbl[11] = '{1,0,0,32'h0,        1,32'hFFFF_FFFC,0,32'h0,        32'h44};
    tbl[12] = '{1,0,0,32'h0,        1,32'h0,        1,32'hFFFF_FFFC,32'h0};

    // Vector table
    start(1'b0, 0);
    for (int i = 0; i < 13; i++) begin
      enable = tbl[i].en; stall = tbl[i].st; pc_src = tbl[i].src; pc_target = tbl[i].tgt;
      tick();
      check($sformatf("row%0d", i), {imem_req, imem_addr, if_valid, instruction, pc_plus4},
            {tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].ins, tbl[i].p4});
      if (i == 3) check("row3_state", dut.state, S_FULL);
    end

    // Streaming with ack tied high: first word at edge 2, then one per cycle
    start(1'b1, 0);
    for (int i = 0; i < 8; i++) push(32'(i * 4));
    sb_on = 1'b1;
    tick();
    check("t1_edge1", {imem_req, if_valid}, 2'b10);
    tick();
    check("t1_edge2", {if_valid, instruction, pc_plus4}, {1'b1, 32'h0, 32'h4});
    for (int i = 0; i < 8; i++) begin
      check("t1_thruput", if_valid, 1'b1);
      tick();
    end
    drain("t1_drain", 2);

    // Delayed ack: exactly once, in order, address held until ack
    start(1'b1, 3);
    for (int i = 0; i < 5; i++) push(32'(i * 4));
    sb_on = 1'b1;
    drain("t2_drain", 200);

    // Stall for 4 cycles while one response is buffered
    start(1'b1, 0);
    for (int i = 0; i < 4; i++) push(32'(i * 4));
    sb_on = 1'b1;
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_frozen", {if_valid, instruction, pc_plus4, imem_req}, {1'b1, 32'h0, 32'h4, 1'b0});
      check("t3_state", dut.state, S_FULL);
    end
    stall = 1'b0;
    drain("t3_drain", 50);

    // Redirect during an outstanding request
    start(1'b1, 3);
    tick();
    pc_src = 1'b1; pc_target = 32'h0000_0103;
    tick();
    pc_src = 1'b0;
    check("t4_drop", {imem_req, imem_addr, if_valid}, {1'b1, 32'h0, 1'b0});
    check("t4_state", dut.state, S_DROP);
    push(32'h100); push(32'h104);
    sb_on = 1'b1;
    begin
      int n = 0;
      while (dut.state != S_REQ && n < 20) begin
        tick();
        n++;
      end
    end
    check("t4_newaddr", {imem_req, imem_addr}, {1'b1, 32'h0000_0100});
    drain("t4_drain", 100);

    // Asynchronous reset mid-request, then wrap at the top of memory
    start(1'b1, 3);
    tick(); tick();
    #3 reset = 1'b0;
    #1;
    check("t6_async_rst", {imem_req, imem_addr, if_valid, instruction, pc_plus4}, '0);
    check("t6_state", dut.state, S_IDLE);
    tick();
    ack_delay = 0; enable = 1'b0; pc_src = 1'b1; pc_target = 32'hFFFF_FFFF;
    tick();
    reset = 1'b1;
    tick();
    pc_src = 1'b0; enable = 1'b1;
    push(32'hFFFF_FFFC); push(32'h0); push(32'h4);
    sb_on = 1'b1;
    drain("t6_drain", 50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
